// File: rtl/proc_pkg.sv
// Shared types and constants for the processor memory-side blocks.
// dmem_state_t: data-memory responder FSM states; dmem_dout_src_t: read-data source select.
// DMEM_OOR_DATA: value returned for a read outside the data array.
package proc_pkg;

    typedef enum logic {
        DMEM_IDLE = 1'b0,
        DMEM_WAIT = 1'b1
    } dmem_state_t;

    // Which value dm_dout_o presents: reset zero, the array read register, or the OOR pattern.
    typedef enum logic [1:0] {
        DOUT_ZERO  = 2'd0,
        DOUT_ARRAY = 2'd1,
        DOUT_OOR   = 2'd2
    } dmem_dout_src_t;

    localparam logic [31:0] DMEM_OOR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with a registered read port (no reset on contents or dout).
// Latency: read data appears one edge after an enabled read; dout_o holds between reads.
// Backpressure: none; accepts an access every cycle en_i is high.
// Ports: clk_i clock; en_i access enable; wen_i 1=write 0=read; addr_i word index;
//        din_i write data; dout_o registered read data.
module dmem_array #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          wen_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   din_i,
    output logic [31:0]   dout_o
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (wen_i) begin
                r_mem[addr_i] <= din_i;
            end else begin
                dout_o <= r_mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core dm_* port: word reads/writes on an internal RAM with range check.
// Latency: 1 cycle zero-wait; with DMEM_WAIT_STATES_EN, busy for WAIT_CYCLES cycles, data at T+N+1.
// Backpressure: dm_busy_o (registered) high while an access is pending; requests then ignored.
// Ports: clk_i, rst_i (sync, active-high); dm_en_i/dm_wen_i/dm_addr_i/dm_din_i request;
//        dm_dout_o read data, dm_busy_o stall, dm_err_o sticky out-of-range flag.
// Macro DMEM_WAIT_STATES_EN: builds the WAIT state and counter; undefined = every access zero-wait.
module dmem_responder
    import proc_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dm_en_i,
    input  logic        dm_wen_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_din_i,
    output logic [31:0] dm_dout_o,
    output logic        dm_busy_o,
    output logic        dm_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // The access being performed at this edge (live request or latched copy).
    logic        w_acc;
    logic        w_acc_wen;
    logic [29:0] w_acc_idx;
    logic [31:0] w_acc_din;
    logic        w_in_range;
    logic        w_arr_en;
    logic [31:0] w_arr_dout;
    logic        w_unused_addr_lsb;

    dmem_dout_src_t r_src;
    logic           r_err;

    assign w_unused_addr_lsb = ^dm_addr_i[1:0];

`ifdef DMEM_WAIT_STATES_EN
    dmem_state_t r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_lat_wen;
    logic [29:0] r_lat_idx;
    logic [31:0] r_lat_din;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= DMEM_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // No reset needed: a latched request is only used from WAIT, which reset leaves.
    always_ff @(posedge clk_i) begin
        if (r_state == DMEM_IDLE && dm_en_i) begin
            r_lat_wen <= dm_wen_i;
            r_lat_idx <= dm_addr_i[31:2];
            r_lat_din <= dm_din_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc       = 1'b0;
        w_acc_wen   = r_lat_wen;
        w_acc_idx   = r_lat_idx;
        w_acc_din   = r_lat_din;
        case (r_state)
            DMEM_IDLE: begin
                if (dm_en_i) begin
                    if (WAIT_CYCLES == 0) begin
                        w_acc     = 1'b1;
                        w_acc_wen = dm_wen_i;
                        w_acc_idx = dm_addr_i[31:2];
                        w_acc_din = dm_din_i;
                    end else begin
                        w_state_nxt = DMEM_WAIT;
                        w_cnt_nxt   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            DMEM_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_acc       = 1'b1;
                    w_state_nxt = DMEM_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = DMEM_IDLE;
            end
        endcase
    end

    // Busy exactly while in WAIT; r_state is a flop, so this output is registered.
    assign dm_busy_o = (r_state == DMEM_WAIT);
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;

    always_comb begin
        w_acc     = dm_en_i;
        w_acc_wen = dm_wen_i;
        w_acc_idx = dm_addr_i[31:2];
        w_acc_din = dm_din_i;
    end

    assign dm_busy_o = 1'b0;
`endif

    // Full 30-bit compare so high address bits never alias onto the array.
    assign w_in_range = (w_acc_idx < 30'(DEPTH_WORDS));
    // Reset suppresses any access, so a pending write is dropped.
    assign w_arr_en   = w_acc & w_in_range & ~rst_i;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i  (clk_i),
        .en_i   (w_arr_en),
        .wen_i  (w_acc_wen),
        .addr_i (w_acc_idx[AW-1:0]),
        .din_i  (w_acc_din),
        .dout_o (w_arr_dout)
    );

    // The array's read register has no reset and only changes on in-range reads, so
    // a source select gives reset-zero and OOR data while the array value holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_src <= DOUT_ZERO;
            r_err <= 1'b0;
        end else begin
            if (w_acc && !w_acc_wen) begin
                r_src <= w_in_range ? DOUT_ARRAY : DOUT_OOR;
            end
            if (w_acc && !w_in_range) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        dm_dout_o = 32'h0;
        case (r_src)
            DOUT_ARRAY: dm_dout_o = w_arr_dout;
            DOUT_OOR:   dm_dout_o = DMEM_OOR_DATA;
            default:    dm_dout_o = 32'h0;
        endcase
    end

    assign dm_err_o = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_WORDS=1024, WAIT_CYCLES=2).
// Expected busy/latency follow N = 2 when DMEM_WAIT_STATES_EN is defined, else N = 0.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
module tb_dmem_responder;

`ifdef DMEM_WAIT_STATES_EN
    localparam int N = 2;
`else
    localparam int N = 0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        busy;
    logic        err;

    int n_vec;
    int n_err;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (2)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .dm_en_i   (en),
        .dm_wen_i  (wen),
        .dm_addr_i (addr),
        .dm_din_i  (din),
        .dm_dout_o (dout),
        .dm_busy_o (busy),
        .dm_err_o  (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request, drop it after acceptance and wait for busy to fall.
    // Returns the number of sampled busy cycles; leaves time at the first idle sample.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int busy_cycles);
        busy_cycles = 0;
        en   = 1'b1;
        wen  = w;
        addr = a;
        din  = d;
        step();
        en = 1'b0;
        while (busy === 1'b1 && busy_cycles < 50) begin
            busy_cycles++;
            step();
        end
        if (busy_cycles >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL access_timeout addr=%h busy still high after %0d cycles", a, busy_cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++;
        if (dout !== 32'h0) begin n_err++; $display("FAIL reset_dout got=%h exp=00000000", dout); end
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset_keeps_array();
        int bc;
        access(1'b1, 32'h10, 32'h1234_5678, bc);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if (dout !== 32'h0) begin n_err++; $display("FAIL pulse_reset_dout got=%h exp=00000000", dout); end
        access(1'b0, 32'h10, 32'h0, bc);
        n_vec++;
        if (dout !== 32'h1234_5678) begin n_err++; $display("FAIL array_survives_reset got=%h exp=12345678", dout); end
    endtask

    task automatic test_write_read();
        int bc;
        access(1'b1, 32'h40, 32'hCAFE_F00D, bc);
        n_vec++;
        if (bc !== N) begin n_err++; $display("FAIL write_busy_cycles got=%0d exp=%0d", bc, N); end
        access(1'b0, 32'h40, 32'h0, bc);
        n_vec++;
        if (bc !== N) begin n_err++; $display("FAIL read_busy_cycles got=%0d exp=%0d", bc, N); end
        n_vec++;
        if (dout !== 32'hCAFE_F00D) begin n_err++; $display("FAIL read_after_write got=%h exp=cafef00d", dout); end
    endtask

`ifndef DMEM_WAIT_STATES_EN
    task automatic test_streaming();
        int bc;
        logic [31:0] exp_v [3];
        exp_v[0] = 32'hA000_0000;
        exp_v[1] = 32'hA000_0004;
        exp_v[2] = 32'hA000_0008;
        for (int i = 0; i < 3; i++) access(1'b1, 32'(i * 4), exp_v[i], bc);
        en  = 1'b1;
        wen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr = 32'(i * 4);
            step();
            n_vec++;
            if (dout !== exp_v[i] || busy !== 1'b0) begin
                n_err++;
                $display("FAIL stream_read%0d got=%h busy=%b exp=%h busy=0", i, dout, busy, exp_v[i]);
            end
        end
        en = 1'b0;
    endtask
`endif

    task automatic test_boundary();
        int bc;
        access(1'b1, 32'h0,   32'h0000_1111, bc);
        access(1'b1, 32'hFFC, 32'h0BAD_F00D, bc);
        access(1'b0, 32'hFFC, 32'h0, bc);
        n_vec++;
        if (dout !== 32'h0BAD_F00D || err !== 1'b0) begin
            n_err++;
            $display("FAIL last_word_read got=%h err=%b exp=0badf00d err=0", dout, err);
        end
        access(1'b0, 32'h1000, 32'h0, bc);
        n_vec++;
        if (dout !== 32'hDEAD_BEEF || err !== 1'b1) begin
            n_err++;
            $display("FAIL oor_read got=%h err=%b exp=deadbeef err=1", dout, err);
        end
        access(1'b1, 32'h1000, 32'h5555_AAAA, bc);
        n_vec++;
        if (dout !== 32'hDEAD_BEEF || err !== 1'b1) begin
            n_err++;
            $display("FAIL oor_write_hold got=%h err=%b exp=deadbeef err=1", dout, err);
        end
        access(1'b0, 32'h0, 32'h0, bc);
        n_vec++;
        if (dout !== 32'h0000_1111) begin n_err++; $display("FAIL oor_write_no_wrap got=%h exp=00001111", dout); end
        access(1'b0, 32'hFFC, 32'h0, bc);
        n_vec++;
        if (dout !== 32'h0BAD_F00D || err !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky got=%h err=%b exp=0badf00d err=1", dout, err);
        end
    endtask

    task automatic test_en_during_reset();
        int bc;
        access(1'b1, 32'h24, 32'h7777_0000, bc);
        rst  = 1'b1;
        en   = 1'b1;
        wen  = 1'b1;
        addr = 32'h24;
        din  = 32'h9999_9999;
        step();
        en  = 1'b0;
        rst = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL en_in_reset_state busy=%b err=%b exp busy=0 err=0", busy, err);
        end
        access(1'b0, 32'h24, 32'h0, bc);
        n_vec++;
        if (dout !== 32'h7777_0000) begin n_err++; $display("FAIL en_in_reset_write got=%h exp=77770000", dout); end
    endtask

`ifdef DMEM_WAIT_STATES_EN
    task automatic test_reset_mid_access();
        int bc;
        access(1'b1, 32'h20, 32'h1111_2222, bc);
        en   = 1'b1;
        wen  = 1'b1;
        addr = 32'h20;
        din  = 32'hAAAA_5555;
        step();
        en  = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || dout !== 32'h0) begin
            n_err++;
            $display("FAIL mid_reset_state busy=%b dout=%h exp busy=0 dout=00000000", busy, dout);
        end
        access(1'b0, 32'h20, 32'h0, bc);
        n_vec++;
        if (dout !== 32'h1111_2222) begin n_err++; $display("FAIL mid_reset_write_dropped got=%h exp=11112222", dout); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        pat  = '0;
        en   = 1'b1;
        wen  = 1'b0;
        addr = 32'h40;
        for (int i = 0; i < 2 * (N + 1); i++) begin
            step();
            pat[i] = busy;
        end
        en = 1'b0;
        n_vec++;
        if (pat !== 6'b011011) begin n_err++; $display("FAIL held_req_busy_pattern got=%b exp=011011", pat); end
        step();
        n_vec++;
        if (busy !== 1'b0 || dout !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL held_req_end busy=%b dout=%h exp busy=0 dout=cafef00d", busy, dout);
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        en    = 1'b0;
        wen   = 1'b0;
        addr  = 32'h0;
        din   = 32'h0;
        #1;
        test_reset();
        test_reset_keeps_array();
        test_write_read();
`ifndef DMEM_WAIT_STATES_EN
        test_streaming();
`endif
        test_boundary();
        test_en_during_reset();
`ifdef DMEM_WAIT_STATES_EN
        test_reset_mid_access();
        test_back_to_back();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
